// File: rtl/ftdi_fifo_bridge.sv
// FT245 parallel-FIFO bridge: host reads fill the RX FIFO, TX FIFO drains to host writes; rxf->rd fall 3 cycles, capture->rx_valid 1 cycle.
// Backpressure: tx_ready drops when TX is full; reads stall while RX is full; writes wait for txe.

module ftdi_fifo_bridge_fifo #(
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          i_push,
    input  logic [7:0]    i_push_dat,
    input  logic          i_pop,
    output logic [7:0]    o_head,
    output logic [LW-1:0] o_level,
    output logic          o_full,
    output logic          o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rptr];
    assign o_level = r_level;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage has no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_push_dat;
    end
endmodule

module ftdi_fifo_bridge #(
    parameter  int FIFO_DEPTH    = 16,
    parameter  int RD_STROBE_CYC = 2,
    parameter  int WR_STROBE_CYC = 2,
    parameter  int TURN_CYC      = 1,
    parameter  int PRIORITY      = 0,
    localparam int L             = $clog2(FIFO_DEPTH) + 1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         rxf,
    input  logic         txe,
    output logic         rd,
    output logic         wr,
    inout  wire  [7:0]   dq,
    output logic         oe,
    input  logic [7:0]   tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic [7:0]   rx_data,
    output logic         rx_valid,
    input  logic         rx_ready,
    output logic [L-1:0] rx_level,
    output logic [L-1:0] tx_level
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD_STROBE = 3'd1;
    localparam logic [2:0] S_WR_SETUP  = 3'd2;
    localparam logic [2:0] S_WR_STROBE = 3'd3;
    localparam logic [2:0] S_WR_HOLD   = 3'd4;
    localparam logic [2:0] S_RECOVER   = 3'd5;

    localparam int REC_CYC  = 2 + TURN_CYC;
    localparam int MAX_RW   = (RD_STROBE_CYC > WR_STROBE_CYC) ? RD_STROBE_CYC : WR_STROBE_CYC;
    localparam int CNT_MAX  = (MAX_RW > REC_CYC) ? MAX_RW : REC_CYC;
    localparam int CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_rd;
    logic          r_wr;
    logic          r_oe;
    logic [7:0]    r_dq_out;
    logic          r_alt;
    logic          r_rxf_m;
    logic          r_rxf_s;
    logic          r_txe_m;
    logic          r_txe_s;

    logic          w_rx_full;
    logic          w_rx_empty;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic [7:0]    w_tx_head;
    logic          w_rd_req;
    logic          w_wr_req;
    logic          w_pick_rd;
    logic          w_pick_wr;
    logic          w_rd_last;
    logic          w_wr_last;
    logic          w_rec_last;
    logic          w_rx_push;
    logic          w_tx_pop;

    assign rd       = r_rd;
    assign wr       = r_wr;
    assign oe       = r_oe;
    assign dq       = r_oe ? r_dq_out : 8'bzzzz_zzzz;
    assign rx_valid = ~w_rx_empty;
    assign tx_ready = ~w_tx_full;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rxf_m <= 1'b1;
            r_rxf_s <= 1'b1;
            r_txe_m <= 1'b1;
            r_txe_s <= 1'b1;
        end else begin
            r_rxf_m <= rxf;
            r_rxf_s <= r_rxf_m;
            r_txe_m <= txe;
            r_txe_s <= r_txe_m;
        end
    end

    assign w_rd_req   = ~r_rxf_s & ~w_rx_full;
    assign w_wr_req   = ~r_txe_s & ~w_tx_empty;
    assign w_rd_last  = (r_cnt == CW'(RD_STROBE_CYC - 1));
    assign w_wr_last  = (r_cnt == CW'(WR_STROBE_CYC - 1));
    assign w_rec_last = (r_cnt == CW'(REC_CYC - 1));
    assign w_rx_push  = (r_state == S_RD_STROBE) && w_rd_last;
    assign w_tx_pop   = (r_state == S_WR_STROBE) && w_wr_last;

    // r_alt names the direction owed the next grant when both sides are pending.
    always_comb begin
        w_pick_rd = 1'b0;
        w_pick_wr = 1'b0;
        if (w_rd_req && w_wr_req) begin
            if (PRIORITY == 1) begin
                w_pick_wr = 1'b1;
            end else if (PRIORITY == 2) begin
                w_pick_wr = r_alt;
                w_pick_rd = ~r_alt;
            end else begin
                w_pick_rd = 1'b1;
            end
        end else begin
            w_pick_rd = w_rd_req;
            w_pick_wr = w_wr_req;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rd     <= 1'b1;
            r_wr     <= 1'b1;
            r_oe     <= 1'b0;
            r_dq_out <= 8'h00;
            r_alt    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_pick_rd) begin
                        r_state <= S_RD_STROBE;
                        r_rd    <= 1'b0;
                        r_alt   <= 1'b1;
                    end else if (w_pick_wr) begin
                        r_state  <= S_WR_SETUP;
                        r_oe     <= 1'b1;
                        r_dq_out <= w_tx_head;
                        r_alt    <= 1'b0;
                    end
                end
                S_RD_STROBE: begin
                    if (w_rd_last) begin
                        r_state <= S_RECOVER;
                        r_rd    <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WR_SETUP: begin
                    r_state <= S_WR_STROBE;
                    r_wr    <= 1'b0;
                    r_cnt   <= '0;
                end
                S_WR_STROBE: begin
                    if (w_wr_last) begin
                        r_state <= S_WR_HOLD;
                        r_wr    <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WR_HOLD: begin
                    r_state <= S_RECOVER;
                    r_oe    <= 1'b0;
                    r_cnt   <= '0;
                end
                S_RECOVER: begin
                    if (w_rec_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_rd    <= 1'b1;
                    r_wr    <= 1'b1;
                    r_oe    <= 1'b0;
                end
            endcase
        end
    end

    ftdi_fifo_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_push     (w_rx_push),
        .i_push_dat (dq),
        .i_pop      (rx_ready),
        .o_head     (rx_data),
        .o_level    (rx_level),
        .o_full     (w_rx_full),
        .o_empty    (w_rx_empty)
    );

    ftdi_fifo_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_push     (tx_valid),
        .i_push_dat (tx_data),
        .i_pop      (w_tx_pop),
        .o_head     (w_tx_head),
        .o_level    (tx_level),
        .o_full     (w_tx_full),
        .o_empty    (w_tx_empty)
    );
endmodule

// File: tb/tb_ftdi_fifo_bridge.sv
// Bench for ftdi_fifo_bridge: host FIFO model on the pins, scoreboards for both byte directions.
module tb_ftdi_fifo_bridge;
    logic       clk = 1'b0;
    logic       n_rst, txe, rd, wr, oe;
    logic       tx_valid, tx_ready, rx_valid, rx_ready, rxf;
    logic [7:0] tx_data, rx_data, host_cur;
    logic [4:0] rx_level, tx_level;
    wire  [7:0] dq;

    always #5 clk = ~clk;

    // Host side: bytes waiting in the FTDI chip, driven onto dq while rd is low.
    logic [7:0] host_mem [64];
    int         host_wr = 0;
    int         host_rd = 0;
    assign rxf      = (host_wr == host_rd);
    assign host_cur = host_mem[host_rd % 64];
    assign dq       = (rd == 1'b0) ? host_cur : 8'bzzzz_zzzz;

    logic [7:0] exp_rx [$];
    logic [7:0] exp_tx [$];
    string      order = "";
    int         n_reads = 0;
    int         n_writes = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    ftdi_fifo_bridge #(.PRIORITY(2)) u_dut (
        .clk(clk), .n_rst(n_rst), .rxf(rxf), .txe(txe), .rd(rd), .wr(wr), .dq(dq), .oe(oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_level(rx_level), .tx_level(tx_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic host_load(input logic [7:0] b);
        host_mem[host_wr % 64] = b;
        host_wr++;
    endtask

    // A completed strobe consumes the host byte; a strobe cut short by reset does not.
    always @(posedge rd) begin
        if (n_rst === 1'b1 && host_wr != host_rd) begin
            exp_rx.push_back(host_cur);
            host_rd++;
            n_reads++;
        end
    end

    logic       p_rd = 1'b1, p_wr = 1'b1, p_oe = 1'b0;
    logic [7:0] p_dq = 8'h00;
    int         rd_w = 0, wr_w = 0;

    always @(negedge clk) begin
        if (n_rst !== 1'b1) begin
            p_rd = 1'b1; p_wr = 1'b1; p_oe = 1'b0; rd_w = 0; wr_w = 0;
        end else begin
            if (!rd) begin
                if (p_rd) order = {order, "R"};
                rd_w++;
            end else if (!p_rd) begin
                check("rd_width", rd_w, 2);
                rd_w = 0;
            end
            if (!wr) begin
                if (p_wr) begin
                    order = {order, "W"};
                    n_writes++;
                end
                check("oe_during_wr", oe, 1);
                wr_w++;
            end else if (!p_wr) begin
                check("wr_width", wr_w, 2);
                wr_w = 0;
                if (exp_tx.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL wr_data: got 0x%0h, expected no write", dq);
                end else begin
                    check("wr_data", dq, exp_tx.pop_front());
                end
            end
            if (oe && p_oe) check("dq_hold", dq, p_dq);
            if (rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rx_data: got 0x%0h, expected no byte", rx_data);
                end else begin
                    check("rx_data", rx_data, exp_rx.pop_front());
                end
            end
            p_rd = rd; p_wr = wr; p_oe = oe; p_dq = dq;
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((host_wr != host_rd || exp_rx.size() != 0 || exp_tx.size() != 0 || !rd || !wr) && k < budget) begin
            cyc();
            k++;
        end
        check("drain_done", k < budget, 1);
        repeat (4) cyc();
    endtask

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic [4:0] lvl;
        logic       rdy;
    } vec_t;

    vec_t vt [18];

    initial begin
        int base, ob, mdl, k;
        string got;

        for (int i = 0; i < 16; i++) begin
            vt[i].vld = 1'b1; vt[i].dat = 8'(i + 1); vt[i].lvl = 5'(i + 1); vt[i].rdy = (i < 15);
        end
        vt[16].vld = 1'b1; vt[16].dat = 8'hEE; vt[16].lvl = 5'd16; vt[16].rdy = 1'b0;
        vt[17].vld = 1'b0; vt[17].dat = 8'h00; vt[17].lvl = 5'd16; vt[17].rdy = 1'b0;

        // Reset with both flags asserted, then one read of 0xA5.
        n_rst = 1'b0; txe = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        host_load(8'hA5);
        repeat (3) begin
            @(negedge clk);
            check("rst_rd", rd, 1);       check("rst_wr", wr, 1);
            check("rst_oe", oe, 0);       check("rst_rx_valid", rx_valid, 0);
            check("rst_tx_ready", tx_ready, 1);
            check("rst_rx_level", rx_level, 0); check("rst_tx_level", tx_level, 0);
        end
        n_rst = 1'b1;
        cyc(); check("rd_idle_c1", rd, 1); check("oe_idle_c1", oe, 0);
        cyc(); check("rd_idle_c2", rd, 1); check("wr_idle_c2", wr, 1);
        cyc(); check("rd_fall_at_c3", rd, 0);
        k = 0;
        while (!rx_valid && k < 20) begin cyc(); k++; end
        check("rx_valid_a5", rx_valid, 1);
        check("rx_level_a5", rx_level, 1);
        check("rx_data_a5", rx_data, 8'hA5);
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;
        check("rx_level_popped", rx_level, 0);
        check("rx_valid_popped", rx_valid, 0);
        check("reads_after_a5", n_reads, 1);

        // TX fill to full through the vector table, then drain to the host.
        txe = 1'b1;
        repeat (3) cyc();
        mdl = 0;
        for (int i = 0; i < 18; i++) begin
            tx_valid = vt[i].vld;
            tx_data  = vt[i].dat;
            if (vt[i].vld && mdl < 16) begin
                exp_tx.push_back(vt[i].dat);
                mdl++;
            end
            cyc();
            tx_valid = 1'b0;
            check($sformatf("tx_level_v%0d", i), tx_level, vt[i].lvl);
            check($sformatf("tx_ready_v%0d", i), tx_ready, vt[i].rdy);
        end
        txe = 1'b0;
        drain(400);
        check("writes_total", n_writes, 16);
        check("tx_level_drained", tx_level, 0);
        check("no_reads_during_tx", n_reads, 1);
        txe = 1'b1;

        // RX backpressure: exactly 16 reads while the consumer stalls, then one more per pop.
        base = n_reads;
        for (int i = 0; i < 20; i++) host_load(8'(8'h40 + i));
        repeat (160) cyc();
        check("reads_until_full", n_reads - base, 16);
        check("rx_level_full", rx_level, 16);
        check("rd_idle_full", rd, 1);
        check("rx_head_full", rx_data, 8'h40);
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;
        repeat (40) cyc();
        check("reads_after_one_pop", n_reads - base, 17);
        check("rx_level_refilled", rx_level, 16);
        rx_ready = 1'b1;
        drain(400);
        check("rx_level_empty", rx_level, 0);

        // Alternating arbitration starts with a read after reset.
        @(negedge clk); n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            tx_valid = 1'b1; tx_data = 8'(8'hB1 + i); exp_tx.push_back(tx_data);
            cyc();
        end
        tx_valid = 1'b0;
        repeat (3) cyc();
        check("tx_level_three", tx_level, 3);
        ob = order.len();
        for (int i = 0; i < 10; i++) host_load(8'(8'hC0 + i));
        txe = 1'b0;
        drain(500);
        got = (order.len() >= ob + 10) ? order.substr(ob, ob + 9) : order.substr(ob, order.len() - 1);
        n_checks++;
        if (got != "RWRWRWRRRR") begin
            n_fail++;
            $display("FAIL arb_order: got %s, expected RWRWRWRRRR", got);
        end
        txe = 1'b1;

        // Reset during the first strobe cycle aborts the read immediately.
        base = n_reads;
        host_load(8'h77);
        k = 0;
        while (rd && k < 20) begin cyc(); k++; end
        check("rd_strobe_seen", rd, 0);
        #1 n_rst = 1'b0;
        #1;
        check("rd_async_reset", rd, 1);
        check("oe_async_reset", oe, 0);
        check("rx_level_async_reset", rx_level, 0);
        @(negedge clk); #1 n_rst = 1'b1;
        cyc(); check("rd_post_rst_c1", rd, 1);
        cyc(); check("rd_post_rst_c2", rd, 1);
        cyc(); check("rd_post_rst_c3", rd, 0);
        drain(100);
        check("reread_after_abort", n_reads - base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
